// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline: drives latch enables, flushes
// and PC control from hazard, redirect, memory-wait and halt conditions.
module pipeline_hazard_ctrl #(
  parameter int CNT_W = 32,
  parameter int REG_W = 5
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             ex_MemRd,
  input  logic [REG_W-1:0] ex_wsel,
  input  logic             ex_redirect,
  input  logic             mem_MemRd,
  input  logic             mem_MemWr,
  input  logic             wb_halt,
  output logic             pc_en,
  output logic             pc_redirect,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [1:0]       state_dbg   // RUN=0, DWAIT=1, HALTED=2
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DWAIT  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             halt_q, halt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic mem_busy;
  logic rs_hit, rt_hit, load_use;

  assign mem_busy = (mem_MemRd | mem_MemWr) & ~dhit;
  assign rs_hit   = id_uses_rs & (id_rs == ex_wsel);
  assign rt_hit   = id_uses_rt & (id_rt == ex_wsel);
  // $0 is hardwired, so a load targeting it never creates a dependency
  assign load_use = ex_MemRd & (ex_wsel != '0) & (rs_hit | rt_hit);

  always_comb begin
    state_d     = state_q;
    halt_d      = halt_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    pc_en       = 1'b0;
    pc_redirect = 1'b0;
    ifid_en     = 1'b0;
    idex_en     = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;

    if (state_q == HALTED) begin
      state_d = HALTED;
    end else if (wb_halt) begin
      state_d = HALTED;
      halt_d  = 1'b1;
    end else if (mem_busy) begin
      state_d     = DWAIT;
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else begin
      // Leaving DWAIT on dhit releases the pipeline in this same cycle
      state_d = RUN;
      if (ex_redirect) begin
        pc_en       = 1'b1;
        pc_redirect = 1'b1;
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end else if (load_use) begin
        idex_flush  = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end else if (!ihit) begin
        ifid_flush  = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end else begin
        pc_en    = 1'b1;
        ifid_en  = 1'b1;
        idex_en  = 1'b1;
        exmem_en = 1'b1;
        memwb_en = 1'b1;
      end
    end

    // Hold every latch and the PC quiet while reset is asserted
    if (!nRST) begin
      pc_en       = 1'b0;
      pc_redirect = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_en    = 1'b0;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= RUN;
      halt_q      <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      halt_q      <= halt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign halt      = halt_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
  assign state_dbg = state_q;

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush scheduler for the 5-stage pipeline. It monitors the ID, EX, MEM and WB stages and the cache handshakes, then drives the enable and flush of every pipeline latch plus the PC. It resolves load-use hazards, redirects on taken branches and jumps, memory waits and halt. It also keeps stall and flush performance counters.

Parameters:
CNT_W, 32, width of performance counters (wrap on overflow)
REG_W, 5, register-select width

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  reset, asynchronous, active-low
ihit  in  1  instruction fetch valid this cycle
dhit  in  1  data access complete this cycle
id_rs  in  REG_W  rs of instruction in ID
id_rt  in  REG_W  rt of instruction in ID
id_uses_rs  in  1  ID instruction reads rs
id_uses_rt  in  1  ID instruction reads rt
ex_MemRd  in  1  EX instruction is a load
ex_wsel  in  REG_W  EX destination register
ex_redirect  in  1  EX resolved taken branch / jump / jr
mem_MemRd  in  1  MEM stage load
mem_MemWr  in  1  MEM stage store
wb_halt  in  1  halt reached WB
pc_en  out  1  PC register load enable
pc_redirect  out  1  PC mux selects EX target (b_addr/j_addr/rdat1)
ifid_en, idex_en, exmem_en, memwb_en  out  1 each  latch enables
ifid_flush, idex_flush, exmem_flush  out  1 each  latch clear (inserts bubble, wins over enable)
halt  out  1  sticky halt to system
stall_cnt  out  CNT_W  cycles with pc_en=0 while in RUN/DWAIT
flush_cnt  out  CNT_W  count of redirects taken

Behaviour:
- FSM states: RUN, DWAIT, HALTED. Reset state is RUN. Reset clears halt=0, stall_cnt=0 and flush_cnt=0.
- While nRST=0, all enable, flush and pc_* outputs are 0.
- Outputs are combinational from state and inputs. State and counters update on the CLK rising edge.
- The conditions below are evaluated in strict priority order. The first match applies.
- HALTED:
  - All enables, flushes and pc_* are 0. halt=1.
  - The FSM stays in HALTED until reset. Counters freeze.
- Halt (any state, wb_halt=1):
  - memwb_en=0, all other enables 0. halt goes to 1 next edge. Next state is HALTED.
- Memory wait ((mem_MemRd|mem_MemWr) & !dhit):
  - Everything is frozen: all enables 0, pc_en=0, no flushes.
  - Next state is DWAIT. stall_cnt increments.
- DWAIT with dhit=1:
  - The pipeline is released in the same cycle, continuing with the remaining priority rules.
  - Next state is RUN.
- Redirect (ex_redirect=1):
  - pc_en=1, pc_redirect=1, ifid_flush=1, idex_flush=1. exmem_en=1, memwb_en=1.
  - flush_cnt increments. This rule is taken regardless of ihit.
  - The load-use rule is ignored because the ID instruction is squashed.
- Load-use:
  - Condition: ex_MemRd & ex_wsel!=0 & ((id_uses_rs & id_rs==ex_wsel) | (id_uses_rt & id_rt==ex_wsel)).
  - pc_en=0, ifid_en=0, idex_flush=1, exmem_en=1, memwb_en=1. stall_cnt increments.
  - Exactly 1 bubble is inserted per hazard.
- Fetch wait (!ihit):
  - pc_en=0, ifid_flush=1, idex_en=1, exmem_en=1, memwb_en=1. stall_cnt increments.
- Otherwise (normal advance):
  - All enables 1, no flushes, pc_redirect=0.
- Register $0 never causes a hazard.
- Counters wrap modulo 2^CNT_W.
- Reset asserted mid-DWAIT returns the FSM to RUN immediately and clears all state.

Test Plan:
- Reset then ihit=1, no hazards -> all enables=1, flushes=0, stall_cnt=0, flush_cnt=0 for 10 cycles.
- ex_MemRd=1, ex_wsel=5, id_rs=5, id_uses_rs=1 for one cycle -> pc_en=0, ifid_en=0, idex_flush=1, stall_cnt=1. The same case with ex_wsel=0 -> no stall.
- mem_MemRd=1, dhit=0 for 3 cycles then dhit=1 -> 3 fully frozen cycles in DWAIT, release on the dhit cycle, stall_cnt=3, state RUN.
- ex_redirect=1 together with a load-use match and ihit=0 -> pc_redirect=1, ifid_flush=1, idex_flush=1, flush_cnt=1, stall_cnt unchanged.
- wb_halt=1 while mem_MemWr=1, dhit=0 -> halt=1 next edge. All outputs stay 0 afterward despite further ihit/redirect until nRST pulses low.
- CNT_W=4, hold ihit=0 for 17 cycles -> stall_cnt wraps to 1. Assert nRST=0 mid-DWAIT -> state RUN and counters 0 asynchronously.
